if_id_buffer: RTL and testbench

- Two-entry skid buffer between the fetch stage and the decode stage of the pipelined RISC-V core.
- Receives each fetch packet {pc, snpc, instr} under a valid/ready handshake and forwards it to decode in order, with one-cycle latency.
- Decode can stall without losing data. The ready signal seen by fetch is registered, so no combinational ready path crosses the boundary.
- Flush discards every held packet. Two saturating performance counters (stall cycles, flushed packets) are exported for the debug bus.

---
 rtl/core_pkg.sv | 20 ++
 rtl/sat_counter.sv | 25 ++
 rtl/if_id_buffer.sv | 131 +++++++++++++
 tb/tb_if_id_buffer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types: fetch packet layout, NOP encoding and IF/ID buffer occupancy.
package core_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] snpc;
      logic [XLEN-1:0] instr;
   } fetch_pkt_t;

   // bit 0 = main entry valid, bit 1 = skid entry valid
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'b00,
      BUF_MAIN  = 2'b01,
      BUF_FULL  = 2'b11
   } buf_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a multi-bit increment, cleared only by reset.
module sat_counter #(
   parameter int WIDTH = 16,
   parameter int INC_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [INC_W-1:0] inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH:0] sum;

   assign sum = {1'b0, count} + (WIDTH+1)'(inc);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (sum[WIDTH])
         count <= '1;
      else
         count <= sum[WIDTH-1:0];
   end

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry skid buffer between fetch and decode with registered ready and flush.
//
// state     | meaning
// BUF_EMPTY | nothing held, in_ready = 1
// BUF_MAIN  | main entry holds the packet presented to decode
// BUF_FULL  | main + skid held, in_ready = 0
module if_id_buffer #(
   parameter int              XLEN      = core_pkg::XLEN,
   parameter int              CNT_W     = 16,
   parameter logic [XLEN-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_snpc,
   input  logic [XLEN-1:0]  in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_snpc,
   output logic [XLEN-1:0]  out_instr,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_drop_cnt
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] snpc;
      logic [XLEN-1:0] instr;
   } pkt_t;

   core_pkg::buf_state_t state, next_state;
   pkt_t main_q, skid_q, in_pkt;
   logic main_valid, skid_valid;
   logic acc, snd;
   logic load_main, main_from_skid, load_skid;
   logic       stall_inc;
   logic [1:0] drop_inc;

   // Occupancy bits are flops, so in_ready never sees a combinational input path.
   assign main_valid = state[0];
   assign skid_valid = state[1];
   assign in_ready   = ~skid_valid;
   assign out_valid  = main_valid & ~flush;

   assign acc    = in_valid & in_ready;
   assign snd    = out_valid & out_ready;
   assign in_pkt = '{pc: in_pc, snpc: in_snpc, instr: in_instr};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= core_pkg::BUF_EMPTY;
      else
         state <= next_state;
   end

   always_comb begin
      next_state     = state;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush) begin
         next_state = core_pkg::BUF_EMPTY;
      end else begin
         case (state)
            core_pkg::BUF_EMPTY: begin
               if (acc) begin
                  load_main  = 1'b1;
                  next_state = core_pkg::BUF_MAIN;
               end
            end
            core_pkg::BUF_MAIN: begin
               if (snd && acc) begin
                  load_main = 1'b1;
               end else if (snd) begin
                  next_state = core_pkg::BUF_EMPTY;
               end else if (acc) begin
                  load_skid  = 1'b1;
                  next_state = core_pkg::BUF_FULL;
               end
            end
            core_pkg::BUF_FULL: begin
               if (snd) begin
                  load_main      = 1'b1;
                  main_from_skid = 1'b1;
                  next_state     = core_pkg::BUF_MAIN;
               end
            end
            default: next_state = core_pkg::BUF_EMPTY;
         endcase
      end
   end

   // Data registers keep their contents across flush; only the valid bits clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q <= '{pc: '0, snpc: '0, instr: NOP_INSTR};
         skid_q <= '0;
      end else begin
         if (load_main)
            main_q <= main_from_skid ? skid_q : in_pkt;
         if (load_skid)
            skid_q <= in_pkt;
      end
   end

   assign out_pc    = main_q.pc;
   assign out_snpc  = main_q.snpc;
   assign out_instr = main_q.instr;

   assign stall_inc = out_valid & ~out_ready;
   assign drop_inc  = flush ? ({1'b0, main_valid} + {1'b0, skid_valid}) : 2'd0;

   sat_counter #(.WIDTH(CNT_W), .INC_W(1)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_W), .INC_W(2)) u_flush_drop_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (drop_inc),
      .count (flush_drop_cnt)
   );

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer with a packet scoreboard and counter model.
module tb_if_id_buffer;

   localparam int XLEN  = 32;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_pc, in_snpc, in_instr;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc, out_snpc, out_instr;
   logic [CNT_W-1:0] stall_cnt, flush_drop_cnt;

   core_pkg::fetch_pkt_t sb[$];
   int exp_stall = 0;
   int exp_drop  = 0;
   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   if_id_buffer #(.XLEN(XLEN), .CNT_W(CNT_W), .NOP_INSTR(32'h00000013)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pc          (in_pc),
      .in_snpc        (in_snpc),
      .in_instr       (in_instr),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_snpc       (out_snpc),
      .out_instr      (out_instr),
      .stall_cnt      (stall_cnt),
      .flush_drop_cnt (flush_drop_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Called at a negedge: drive inputs, sample mid-cycle, update the model, wait a cycle.
   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                        input logic ordy, input logic fl);
      core_pkg::fetch_pkt_t p;
      int sz;
      in_valid  = v;
      in_pc     = pc;
      in_snpc   = pc + 32'd4;
      in_instr  = instr;
      out_ready = ordy;
      flush     = fl;
      #1;
      sz = sb.size();
      chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      chk("flush_drop_cnt", 32'(flush_drop_cnt), 32'(exp_drop));
      chk("in_ready", {31'd0, in_ready}, (sz < 2) ? 32'd1 : 32'd0);
      chk("out_valid", {31'd0, out_valid}, (sz > 0 && !fl) ? 32'd1 : 32'd0);
      if (sz > 0) begin
         chk("out_pc", out_pc, sb[0].pc);
         chk("out_snpc", out_snpc, sb[0].snpc);
         chk("out_instr", out_instr, sb[0].instr);
      end
      if (fl) begin
         exp_drop = (exp_drop + sz > CMAX) ? CMAX : exp_drop + sz;
         sb.delete();
      end else begin
         if (sz > 0 && !ordy && exp_stall < CMAX)
            exp_stall++;
         if (sz > 0 && ordy)
            void'(sb.pop_front());
         if (v && sz < 2) begin
            p.pc    = pc;
            p.snpc  = pc + 32'd4;
            p.instr = instr;
            sb.push_back(p);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_pc     = '0;
      in_snpc   = '0;
      in_instr  = '0;
      out_ready = 1'b0;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_snpc", out_snpc, 32'd0);
      chk("rst_out_instr", out_instr, 32'h00000013);
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // single packet
      drive(1'b1, 32'h80000000, 32'h00500093, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // back-pressure fill, then a rejected offer while full, then drain
      drive(1'b1, 32'h100, 32'h11100093, 1'b0, 1'b0);
      drive(1'b1, 32'h104, 32'h22200093, 1'b0, 1'b0);
      drive(1'b1, 32'h108, 32'h33300093, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // streaming
      for (int i = 0; i < 20; i++)
         drive(1'b1, 32'h1000 + 32'(i * 4), 32'h00000013 + 32'(i << 20), 1'b1, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // flush while full, with a concurrent offer that must be dropped
      drive(1'b1, 32'h300, 32'h44400093, 1'b0, 1'b0);
      drive(1'b1, 32'h304, 32'h55500093, 1'b0, 1'b0);
      drive(1'b1, 32'h200, 32'h66600093, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("drop_after_flush", 32'(flush_drop_cnt), 32'd2);

      // async reset between edges while full
      drive(1'b1, 32'h500, 32'h77700093, 1'b0, 1'b0);
      drive(1'b1, 32'h504, 32'h88800093, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("arst_out_instr", out_instr, 32'h00000013);
      chk("arst_out_pc", out_pc, 32'd0);
      chk("arst_stall", 32'(stall_cnt), 32'd0);
      chk("arst_drop", 32'(flush_drop_cnt), 32'd0);
      sb.delete();
      exp_stall = 0;
      exp_drop  = 0;
      @(negedge clk);
      rst = 1'b1;

      // stall counter saturation
      drive(1'b1, 32'h400, 32'h99900093, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      chk("stall_saturated", 32'(stall_cnt), 32'(CMAX));
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
